// File: rtl/servo_pwm_bank_pkg.sv
// Shared defaults and helpers for the servo PWM bank.
// Duties and the period are expressed in clk cycles.
package servo_pwm_bank_pkg;

    localparam int DEF_CHANNELS  = 4;
    localparam int DEF_CNT_W     = 20;
    localparam int DEF_PERIOD    = 1_000_000;
    localparam int DEF_DUTY_MIN  = 25_000;
    localparam int DEF_DUTY_MAX  = 125_000;
    localparam int DEF_INIT_DUTY = 75_000;
    localparam int DEF_STEP      = 500;

    // Channel index width; a single channel still needs a 1-bit index port.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/servo_pwm_bank_if.sv
// Setpoint command port of the servo PWM bank (valid/ready plus error pulse).
interface servo_pwm_bank_if
    import servo_pwm_bank_pkg::*;
#(
    parameter int CH_W  = ch_width(DEF_CHANNELS),
    parameter int CNT_W = DEF_CNT_W
) ();

    logic             cmd_valid;
    logic             cmd_ready;
    logic [CH_W-1:0]  cmd_ch;
    logic [CNT_W-1:0] cmd_duty;
    logic             cmd_err;

    modport master (
        output cmd_valid, cmd_ch, cmd_duty,
        input  cmd_ready, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd_ch, cmd_duty,
        output cmd_ready, cmd_err
    );

endinterface

// File: rtl/servo_pwm_bank_ramp.sv
// One servo channel: clamped target, slew-limited applied duty, PWM compare.
// The applied duty only moves on the boundary strobe so pulses are never truncated.
module servo_pwm_bank_ramp
    import servo_pwm_bank_pkg::*;
#(
    parameter int CNT_W     = DEF_CNT_W,
    parameter int DUTY_MIN  = DEF_DUTY_MIN,
    parameter int DUTY_MAX  = DEF_DUTY_MAX,
    parameter int INIT_DUTY = DEF_INIT_DUTY,
    parameter int STEP      = DEF_STEP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             boundary_i,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] duty_i,
    input  logic [CNT_W-1:0] count_i,
    output logic             pwm_o,
    output logic             diff_o
);

    localparam logic [CNT_W-1:0]   MIN_D  = CNT_W'(DUTY_MIN);
    localparam logic [CNT_W-1:0]   MAX_D  = CNT_W'(DUTY_MAX);
    localparam logic [CNT_W-1:0]   INIT_D = CNT_W'(INIT_DUTY);
    localparam logic [CNT_W-1:0]   STEP_D = CNT_W'(STEP);
    localparam logic signed [CNT_W:0] STEP_S = (CNT_W+1)'(STEP);

    logic [CNT_W-1:0]        target_q, target_d;
    logic [CNT_W-1:0]        cur_q, cur_d;
    logic [CNT_W-1:0]        clamped;
    logic signed [CNT_W:0]   delta;
    logic                    pwm_q;

    always_comb begin
        clamped = duty_i;
        if (duty_i < MIN_D) begin
            clamped = MIN_D;
        end else if (duty_i > MAX_D) begin
            clamped = MAX_D;
        end
    end

    assign target_d = wr_i ? clamped : target_q;

    // One extra bit keeps the signed distance free of wrap-around.
    assign delta = $signed({1'b0, target_q}) - $signed({1'b0, cur_q});

    always_comb begin
        cur_d = cur_q;
        if (boundary_i) begin
            if ((STEP == 0) || ((delta <= STEP_S) && (delta >= -STEP_S))) begin
                cur_d = target_q;
            end else if (delta > 0) begin
                cur_d = cur_q + STEP_D;
            end else begin
                cur_d = cur_q - STEP_D;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            target_q <= INIT_D;
            cur_q    <= INIT_D;
            pwm_q    <= 1'b0;
        end else begin
            target_q <= target_d;
            cur_q    <= cur_d;
            pwm_q    <= (count_i < cur_q);
        end
    end

    assign pwm_o  = pwm_q;
    assign diff_o = (target_q != cur_q);

endmodule

// File: rtl/servo_pwm_bank.sv
// Multi-channel servo PWM bank: shared period counter, command handshake,
// error/frame/busy flags; per-channel ramps do the duty work.
module servo_pwm_bank
    import servo_pwm_bank_pkg::*;
#(
    parameter int CHANNELS  = DEF_CHANNELS,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int PERIOD    = DEF_PERIOD,
    parameter int DUTY_MIN  = DEF_DUTY_MIN,
    parameter int DUTY_MAX  = DEF_DUTY_MAX,
    parameter int INIT_DUTY = DEF_INIT_DUTY,
    parameter int STEP      = DEF_STEP
) (
    input  logic                clk,
    input  logic                rst,
    servo_pwm_bank_if.slave     cmd,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                frame_start,
    output logic                busy
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0]    count_q, count_d;
    logic                boundary;
    logic                fire;
    logic                ready_q;
    logic                err_q;
    logic                frame_q;
    logic                busy_q;
    logic [CHANNELS-1:0] diff_ch;

    assign boundary = (count_q == LAST);
    assign count_d  = boundary ? '0 : count_q + 1'b1;
    assign fire     = cmd.cmd_valid && ready_q;

    // Ready is computed from the next count so it is already low in the boundary cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            frame_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            ready_q <= (count_d != LAST);
            err_q   <= fire && (int'(cmd.cmd_ch) >= CHANNELS);
            frame_q <= boundary;
            busy_q  <= |diff_ch;
        end
    end

    assign cmd.cmd_ready = ready_q;
    assign cmd.cmd_err   = err_q;
    assign frame_start   = frame_q;
    assign busy          = busy_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        servo_pwm_bank_ramp #(
            .CNT_W     (CNT_W),
            .DUTY_MIN  (DUTY_MIN),
            .DUTY_MAX  (DUTY_MAX),
            .INIT_DUTY (INIT_DUTY),
            .STEP      (STEP)
        ) u_ramp (
            .clk        (clk),
            .rst        (rst),
            .boundary_i (boundary),
            .wr_i       (fire && (int'(cmd.cmd_ch) == i)),
            .duty_i     (cmd.cmd_duty),
            .count_i    (count_q),
            .pwm_o      (pwm_out[i]),
            .diff_o     (diff_ch[i])
        );
    end

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Bench for servo_pwm_bank: directed scenarios plus random setpoints, checked
// cycle by cycle against a per-period pulse-width model.
module tb_servo_pwm_bank;
    import servo_pwm_bank_pkg::*;

    localparam int CH     = 4;
    localparam int CNT_W  = 8;
    localparam int PERIOD = 20;
    localparam int DMIN   = 2;
    localparam int DMAX   = 16;
    localparam int DINIT  = 8;
    localparam int STEP   = 3;

    logic clk;
    logic rst;
    logic [CH-1:0] pwm_out;
    logic frame_start;
    logic busy;
    logic [2:0] pwm3;
    logic frame3;
    logic busy3;

    servo_pwm_bank_if #(.CH_W(ch_width(CH)), .CNT_W(CNT_W)) ifc ();
    servo_pwm_bank_if #(.CH_W(ch_width(3)), .CNT_W(CNT_W)) if3 ();

    servo_pwm_bank #(
        .CHANNELS(CH), .CNT_W(CNT_W), .PERIOD(PERIOD), .DUTY_MIN(DMIN),
        .DUTY_MAX(DMAX), .INIT_DUTY(DINIT), .STEP(STEP)
    ) u_dut (
        .clk(clk), .rst(rst), .cmd(ifc.slave),
        .pwm_out(pwm_out), .frame_start(frame_start), .busy(busy)
    );

    servo_pwm_bank #(
        .CHANNELS(3), .CNT_W(CNT_W), .PERIOD(PERIOD), .DUTY_MIN(DMIN),
        .DUTY_MAX(DMAX), .INIT_DUTY(DINIT), .STEP(STEP)
    ) u_dut3 (
        .clk(clk), .rst(rst), .cmd(if3.slave),
        .pwm_out(pwm3), .frame_start(frame3), .busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: target and applied duty per channel, stepped once per period.
    int tgt[CH];
    int cur[CH];
    int idx = 0;
    bit synced = 0;
    bit busy_exp = 0;
    logic [CH-1:0] ev_pwm;

    function automatic int clampd(input int d);
        if (d < DMIN) return DMIN;
        if (d > DMAX) return DMAX;
        return d;
    endfunction

    function automatic int stepd(input int c, input int t);
        if (t - c > STEP) return c + STEP;
        if (c - t > STEP) return c - STEP;
        return t;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            tgt[i] = DINIT;
            cur[i] = DINIT;
        end
    endtask

    // The pulse of a period is visible for cur cycles starting one cycle after frame_start.
    always @(negedge clk) begin
        if (rst) begin
            synced = 0;
        end else begin
            if (frame_start) begin
                if (synced) chk("frame_spacing", idx + 1, PERIOD);
                synced = 1;
                idx = 0;
                busy_exp = 0;
                for (int i = 0; i < CH; i++) begin
                    cur[i] = stepd(cur[i], tgt[i]);
                    if (cur[i] != tgt[i]) busy_exp = 1;
                end
            end else if (synced) begin
                idx++;
            end
            if (synced) begin
                if (idx >= PERIOD) begin
                    chk("frame_missing", idx, PERIOD - 1);
                    synced = 0;
                end else begin
                    for (int i = 0; i < CH; i++) ev_pwm[i] = (idx >= 1) && (idx <= cur[i]);
                    chk("pwm", pwm_out, ev_pwm);
                    chk("ready", ifc.cmd_ready, idx != PERIOD - 1);
                    chk("err", ifc.cmd_err, 0);
                    if (idx == 1) chk("busy", busy, busy_exp);
                end
            end
        end
    end

    task automatic send(input int ch, input int duty);
        int n;
        n = 0;
        @(negedge clk);
        ifc.cmd_valid = 1'b1;
        ifc.cmd_ch    = ch[1:0];
        ifc.cmd_duty  = duty[CNT_W-1:0];
        while (!ifc.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ifc.cmd_ready) chk("send_timeout", 0, 1);
        @(posedge clk);
        tgt[ch] = clampd(duty);
        #1 ifc.cmd_valid = 1'b0;
    endtask

    task automatic wait_idx(input int k);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(synced && idx == k) && n < 100);
        if (!(synced && idx == k)) chk("wait_idx_timeout", idx, k);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_pwm"}, pwm_out, 0);
        chk({tag, "_frame"}, frame_start, 0);
        chk({tag, "_err"}, ifc.cmd_err, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ready"}, ifc.cmd_ready, 0);
        chk({tag, "_pwm3"}, pwm3, 0);
    endtask

    initial begin
        int hi[3];
        int errs;
        int n;
        rst = 1'b1;
        ifc.cmd_valid = 1'b0; ifc.cmd_ch = '0; ifc.cmd_duty = '0;
        if3.cmd_valid = 1'b0; if3.cmd_ch = '0; if3.cmd_duty = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Idle: every channel 8 high / 12 low.
        repeat (3 * PERIOD) @(negedge clk);

        // Ramp up ch1 with a clamped setpoint.
        wait_idx(7);
        send(1, 17);
        repeat (6 * PERIOD) @(negedge clk);

        // Ramp down ch2 and a small step on ch3.
        send(2, 0);
        send(3, 9);
        repeat (4 * PERIOD) @(negedge clk);

        // Command held across the boundary, then a second write in the same period.
        wait_idx(PERIOD - 1);
        ifc.cmd_valid = 1'b1; ifc.cmd_ch = 2'd0; ifc.cmd_duty = 8'd5;
        chk("ready_boundary", ifc.cmd_ready, 0);
        @(negedge clk);
        chk("ready_after_boundary", ifc.cmd_ready, 1);
        @(posedge clk);
        tgt[0] = clampd(5);
        #1 ifc.cmd_valid = 1'b0;
        send(0, 12);
        repeat (4 * PERIOD) @(negedge clk);

        // Out-of-range channel on the 3-channel instance.
        @(negedge clk);
        if3.cmd_valid = 1'b1; if3.cmd_ch = 2'd3; if3.cmd_duty = 8'd3;
        n = 0;
        while (!if3.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 if3.cmd_valid = 1'b0;
        @(negedge clk);
        chk("err3_pulse", if3.cmd_err, 1);
        errs = 0;
        for (int i = 0; i < 3; i++) hi[i] = 0;
        for (int c = 0; c < 2 * PERIOD; c++) begin
            @(negedge clk);
            if (if3.cmd_err) errs++;
            if (c >= PERIOD) begin
                for (int i = 0; i < 3; i++) hi[i] += int'(pwm3[i]);
            end
        end
        chk("err3_single", errs, 0);
        for (int i = 0; i < 3; i++) chk("pwm3_width", hi[i], DINIT);
        chk("busy3", busy3, 0);

        // Reset in the middle of a ramp (ch1 at 11 heading for 16).
        send(1, 8);
        repeat (5 * PERIOD) @(negedge clk);
        send(1, 17);
        wait_idx(0);
        wait_idx(5);
        rst = 1'b1;
        model_reset();
        #1 check_reset_outputs("rst_ramp");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3 * PERIOD) @(negedge clk);
        chk("busy_after_reset", busy, 0);

        // Random setpoints at random times.
        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 15)) @(negedge clk);
            send(int'($urandom_range(0, CH - 1)), int'($urandom_range(0, 20)));
        end
        repeat (8 * PERIOD) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
